matrix_scan_ctrl: RTL and testbench
===================================

MATRIX_SCAN_CTRL -- requirements
Module: matrix_scan_ctrl

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 4: clocks each dot is held, legal 1..255.
REQ-002 SHALL have port CLK, input, 1, the single system clock; all logic on its rising edge.
REQ-003 SHALL have port RST, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port EN, input, 1, scan enable.
REQ-005 SHALL have port LOAD, input, 1, single-cycle strobe that captures FRAME.
REQ-006 SHALL have port FRAME, input, 35, pixel bitmap; bit r*5+c drives matrix row r (0..6), column c (0..4).
REQ-007 SHALL have ports SEL0, SEL1, SEL2, output, 1 each, column code, SEL0 = MSB.
REQ-008 SHALL have ports SEL3, SEL4, SEL5, output, 1 each, row code, SEL3 = MSB.
REQ-009 SHALL have port IPT, output, 1, dot drive bit for the downstream 1-to-35 demultiplexer.
REQ-010 SHALL have port FRAME_DONE, output, 1, one-cycle pulse at frame wrap.
REQ-011 SHALL have port BUSY, output, 1, high while not in IDLE.

Function
REQ-012 SHALL scan dot index d = 0..34, c = d mod 5 (inner), r = d div 5 (outer).
REQ-013 SHALL output column code c+1 on SEL0..SEL2 and row code r+1 on SEL3..SEL5; code 000 never occurs outside IDLE.
REQ-014 SHALL drive IPT = active-buffer bit d during SCAN, 0 in every other state.
REQ-015 SHALL implement states IDLE, SCAN, BLANK; IDLE drives all SEL and IPT to 0.
REQ-016 SHALL go IDLE -> SCAN at d = 0 on the first cycle after EN is sampled high.
REQ-017 SHALL hold each dot in SCAN for exactly DWELL_CYCLES clocks, counted by an 8-bit dwell counter.
REQ-018 SHALL, at end of dwell, advance d (or go to BLANK first, see REQ-027); after d = 34, wrap to 0.
REQ-019 SHALL pulse FRAME_DONE in the last dwell cycle of d = 34.
REQ-020 SHALL, on EN sampled low in any state, enter IDLE next cycle with d and the dwell counter cleared.
REQ-021 SHALL hold two 35-bit buffers: shadow and active; LOAD writes FRAME to shadow and sets a pending flag.
REQ-022 SHALL copy shadow to active and clear pending only at frame wrap; no mid-frame tearing.
REQ-023 SHALL, on LOAD while IDLE, write FRAME to both buffers directly; pending stays 0.
REQ-024 SHALL, on LOAD coinciding with the wrap cycle, load the new FRAME into active for the next frame.
REQ-025 SHALL keep only the last of several LOADs within one frame.

Reset
REQ-026 SHALL, with RST high at a clock edge: state IDLE, d = 0, dwell = 0, both buffers and pending = 0, SEL0..SEL5 = 0, IPT = 0, FRAME_DONE = 0, BUSY = 0; RST overrides EN and LOAD; reset mid-scan aborts immediately.

Configuration
REQ-027 SHALL, with macro MATRIX_SCAN_BLANK_EN defined, insert one BLANK cycle after every dot (IPT = 0, SEL holding the next dot's codes) before SCAN of the next dot.
REQ-028 SHALL, without MATRIX_SCAN_BLANK_EN, omit BLANK: frame period = 35*DWELL_CYCLES clocks (with it: 35*(DWELL_CYCLES+1)).

Verification
REQ-029 SHALL check reset: RST high 2 cycles during scan -> all outputs 0, BUSY 0 next cycle.
REQ-030 SHALL check mapping: DWELL_CYCLES = 1, no macro, FRAME = bit 0 and bit 34 only -> IPT high with SEL = 001/001 at d = 0 and SEL = 101/111 at d = 34; FRAME_DONE every 35 clocks.
REQ-031 SHALL check dwell: DWELL_CYCLES = 4, FRAME all ones -> each SEL code stable 4 clocks, frame period 140 clocks.
REQ-032 SHALL check double buffering: LOAD 0x0 mid-frame over all-ones -> IPT remains 1 until wrap, 0 from next frame.
REQ-033 SHALL check EN drop at d = 17 -> IDLE next cycle, SEL = 000000; re-enable restarts at d = 0.
REQ-034 SHALL check macro build, DWELL_CYCLES = 2: IPT low every third clock, frame period 105 clocks.

Source files
------------

// File: rtl/matrix_scan_ctrl.sv
// matrix_scan_ctrl: drives a 5x7 dot matrix one dot at a time through a row/column
// demultiplexer code, with a double-buffered frame so new images never tear mid-frame.
// Latency: outputs are registered; SEL/IPT/BUSY reflect the state entered at each edge.
// Backpressure: none; LOAD is accepted any cycle, and only the last LOAD before a wrap is kept.
//
// Ports:
//   CLK, RST       - rising-edge clock, synchronous active-high reset
//   EN             - scan enable; low returns to IDLE on the next edge
//   LOAD, FRAME    - single-cycle strobe capturing the 35-bit bitmap (bit r*5+c)
//   SEL0..SEL2     - column code c+1 (SEL0 = MSB)
//   SEL3..SEL5     - row code r+1 (SEL3 = MSB)
//   IPT            - dot drive bit, only asserted in SCAN
//   FRAME_DONE     - one-cycle pulse in the last dwell cycle of dot 34
//   BUSY           - high whenever not in IDLE
// Build option: define MATRIX_SCAN_BLANK_EN to insert one blank cycle after every dot.

module matrix_scan_ctrl #(
  parameter int unsigned DWELL_CYCLES = 4  // clocks per dot, 1..255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        LOAD,
  input  logic [34:0] FRAME,
  output logic        SEL0,
  output logic        SEL1,
  output logic        SEL2,
  output logic        SEL3,
  output logic        SEL4,
  output logic        SEL5,
  output logic        IPT,
  output logic        FRAME_DONE,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL_CYCLES - 1);

`ifdef MATRIX_SCAN_BLANK_EN
  localparam logic BLANK_EN = 1'b1;
`else
  localparam logic BLANK_EN = 1'b0;
`endif

  state_t      state_q, state_d;
  logic [2:0]  col_q, col_d;      // c = d mod 5
  logic [2:0]  row_q, row_d;      // r = d div 5
  logic [7:0]  dwell_q, dwell_d;
  logic [34:0] shadow_q, shadow_d;
  logic [34:0] active_q, active_d;
  logic        pending_q, pending_d;

  logic [5:0]  sel_q;             // {column code, row code}
  logic        ipt_q;
  logic        frame_done_q;
  logic        busy_q;

  logic        last_dot;
  logic        dwell_end;
  logic        wrap;
  logic [5:0]  idx_d;

  assign last_dot  = (col_q == 3'd4) && (row_q == 3'd6);
  assign dwell_end = (dwell_q == DWELL_LAST);

  // Bit index of the dot being presented next cycle.
  assign idx_d = ({3'b000, row_d} * 6'd5) + {3'b000, col_d};

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    dwell_d   = dwell_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    wrap      = 1'b0;

    case (state_q)
      IDLE: begin
        if (EN) begin
          state_d = SCAN;
          col_d   = 3'd0;
          row_d   = 3'd0;
          dwell_d = 8'd0;
        end
      end
      SCAN: begin
        if (dwell_end) begin
          dwell_d = 8'd0;
          // Dot index advances at end of dwell; in the blank build the blank
          // cycle already presents the next dot's codes.
          if (last_dot) begin
            wrap  = 1'b1;
            col_d = 3'd0;
            row_d = 3'd0;
          end else if (col_q == 3'd4) begin
            col_d = 3'd0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
          state_d = BLANK_EN ? BLANK : SCAN;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      BLANK: begin
        state_d = SCAN;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // EN low wins over everything except reset.
    if (!EN) begin
      state_d = IDLE;
      col_d   = 3'd0;
      row_d   = 3'd0;
      dwell_d = 8'd0;
      wrap    = 1'b0;
    end

    // Active buffer only changes while idle or exactly at the frame wrap.
    if (LOAD && ((state_q == IDLE) || wrap)) begin
      shadow_d  = FRAME;
      active_d  = FRAME;
      pending_d = 1'b0;
    end else if (LOAD) begin
      shadow_d  = FRAME;
      pending_d = 1'b1;
    end else if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      col_q        <= 3'd0;
      row_q        <= 3'd0;
      dwell_q      <= 8'd0;
      shadow_q     <= 35'd0;
      active_q     <= 35'd0;
      pending_q    <= 1'b0;
      sel_q        <= 6'd0;
      ipt_q        <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      dwell_q      <= dwell_d;
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      // Outputs are registered from next-state values so they line up with state_q.
      sel_q        <= (state_d == IDLE) ? 6'd0 : {col_d + 3'd1, row_d + 3'd1};
      ipt_q        <= (state_d == SCAN) && active_d[idx_d];
      frame_done_q <= (state_d == SCAN) && (col_d == 3'd4) && (row_d == 3'd6) &&
                      (dwell_d == DWELL_LAST);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign SEL0       = sel_q[5];
  assign SEL1       = sel_q[4];
  assign SEL2       = sel_q[3];
  assign SEL3       = sel_q[2];
  assign SEL4       = sel_q[1];
  assign SEL5       = sel_q[0];
  assign IPT        = ipt_q;
  assign FRAME_DONE = frame_done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Testbench for matrix_scan_ctrl: two instances (dwell 1 and dwell 4) share stimulus.
// Expected outputs come from a dot-timing model plus a bench copy of the buffer rules.
// Output vector per instance: {SEL0..SEL5, IPT, FRAME_DONE, BUSY}.

module tb_matrix_scan_ctrl;

`ifdef MATRIX_SCAN_BLANK_EN
  localparam int BLK = 1;
`else
  localparam int BLK = 0;
`endif
  localparam int PB = 4 + BLK;  // clocks per dot for the dwell-4 instance

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        LOAD = 1'b0;
  logic [34:0] FRAME = 35'd0;

  logic a_s0, a_s1, a_s2, a_s3, a_s4, a_s5, a_ipt, a_fd, a_busy;
  logic b_s0, b_s1, b_s2, b_s3, b_s4, b_s5, b_ipt, b_fd, b_busy;
  logic [8:0] obs_a, obs_b;

  assign obs_a = {a_s0, a_s1, a_s2, a_s3, a_s4, a_s5, a_ipt, a_fd, a_busy};
  assign obs_b = {b_s0, b_s1, b_s2, b_s3, b_s4, b_s5, b_ipt, b_fd, b_busy};

  always #5 CLK = ~CLK;

  matrix_scan_ctrl #(.DWELL_CYCLES(1)) u_dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .FRAME(FRAME),
    .SEL0(a_s0), .SEL1(a_s1), .SEL2(a_s2), .SEL3(a_s3), .SEL4(a_s4), .SEL5(a_s5),
    .IPT(a_ipt), .FRAME_DONE(a_fd), .BUSY(a_busy)
  );

  matrix_scan_ctrl #(.DWELL_CYCLES(4)) u_dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .FRAME(FRAME),
    .SEL0(b_s0), .SEL1(b_s1), .SEL2(b_s2), .SEL3(b_s3), .SEL4(b_s4), .SEL5(b_s5),
    .IPT(b_ipt), .FRAME_DONE(b_fd), .BUSY(b_busy)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int k        = 0;  // cycles since entering SCAN

  logic [34:0] act_a, shd_a, act_b, shd_b;
  logic        pnd_a, pnd_b;

  localparam logic [34:0] MAP  = 35'h400000001;
  localparam logic [34:0] P1   = 35'h555555555;
  localparam logic [34:0] P2   = 35'h2AAAAAAAA;
  localparam logic [34:0] ONES = {35{1'b1}};

  // Expected outputs for dwell D at cycle kk of a running scan.
  function automatic logic [8:0] exp_out(input int D, input int kk, input logic [34:0] act);
    int per, f, d, ph, dd, col, row;
    logic scan, fd, bit_d;
    per   = D + BLK;
    f     = kk % (35 * per);
    d     = f / per;
    ph    = f % per;
    scan  = (ph < D);
    dd    = scan ? d : ((d + 1) % 35);
    col   = (dd % 5) + 1;
    row   = (dd / 5) + 1;
    bit_d = act[6'(d)];
    fd    = scan && (d == 34) && (ph == D - 1);
    return {3'(col), 3'(row), scan & bit_d, fd, 1'b1};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, exp);
    end
  endtask

  // Check the current cycle, optionally pulse LOAD, then advance one clock.
  task automatic step(input logic ld, input logic [34:0] fr);
    logic [8:0] ea, eb;
    ea = exp_out(1, k, act_a);
    eb = exp_out(4, k, act_b);
    check("scan_a", obs_a, ea);
    check("scan_b", obs_b, eb);
    if (ld) begin
      if (ea[1]) begin act_a = fr; shd_a = fr; pnd_a = 1'b0; end
      else begin shd_a = fr; pnd_a = 1'b1; end
      if (eb[1]) begin act_b = fr; shd_b = fr; pnd_b = 1'b0; end
      else begin shd_b = fr; pnd_b = 1'b1; end
    end else begin
      if (ea[1] && pnd_a) begin act_a = shd_a; pnd_a = 1'b0; end
      if (eb[1] && pnd_b) begin act_b = shd_b; pnd_b = 1'b0; end
    end
    LOAD  = ld;
    FRAME = fr;
    tick();
    LOAD  = 1'b0;
    k++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 35'd0);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check("reset_a", obs_a, 9'b0);
    check("reset_b", obs_b, 9'b0);

    // Mapping image loaded while idle goes straight to the active buffer.
    RST = 1'b0;
    LOAD = 1'b1;
    FRAME = MAP;
    tick();
    LOAD = 1'b0;
    check("idle_load_a", obs_a, 9'b0);
    check("idle_load_b", obs_b, 9'b0);
    act_a = MAP; shd_a = MAP; pnd_a = 1'b0;
    act_b = MAP; shd_b = MAP; pnd_b = 1'b0;
    EN = 1'b1;
    tick();
    k = 0;
    check("first_dot_a", obs_a, 9'b001_001_1_0_1);
    check("first_dot_b", obs_b, 9'b001_001_1_0_1);
    run(75);

    // Reset held two cycles mid-scan with EN still high.
    RST = 1'b1;
    tick();
    check("rst1_a", obs_a, 9'b0);
    check("rst1_b", obs_b, 9'b0);
    tick();
    check("rst2_a", obs_a, 9'b0);
    check("rst2_b", obs_b, 9'b0);

    // All-ones image, then double-buffer timeline.
    RST = 1'b0;
    EN = 1'b0;
    LOAD = 1'b1;
    FRAME = ONES;
    tick();
    LOAD = 1'b0;
    check("idle2_a", obs_a, 9'b0);
    check("idle2_b", obs_b, 9'b0);
    act_a = ONES; shd_a = ONES; pnd_a = 1'b0;
    act_b = ONES; shd_b = ONES; pnd_b = 1'b0;
    EN = 1'b1;
    tick();
    k = 0;

    run(60);
    step(1'b1, 35'd0);          // mid-frame LOAD of blank image
    run(160 - k);
    step(1'b1, P1);             // two LOADs in one frame: only P2 survives
    run(170 - k);
    step(1'b1, P2);
    run(3 * 35 * PB - 1 - k);
    step(1'b1, ONES);           // LOAD exactly on the wrap cycle of the dwell-4 instance
    run(17 * PB + 2);

    // EN drop while the dwell-4 instance is on dot 17.
    check("pre_drop_a", obs_a, exp_out(1, k, act_a));
    check("pre_drop_b", obs_b, exp_out(4, k, act_b));
    check("dot17_b_sel", {obs_b[8:3], 3'b000}, {3'd3, 3'd4, 3'b000});
    EN = 1'b0;
    tick();
    check("drop_a", obs_a, 9'b0);
    check("drop_b", obs_b, 9'b0);
    EN = 1'b1;
    tick();
    k = 0;
    check("restart_b", obs_b, 9'b001_001_1_0_1);
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
